icache_refill_axi_rd: RTL and testbench
=======================================

Name: icache_refill_axi_rd

Overview:
- AXI4 read master that turns single ICache line-refill / uncached-fetch requests into one AXI4 read burst.
- Collects the returned beats into a line buffer and hands the whole line back to the ICache.
- Drives the ICache slave port (s00) of the 2x1 AXI interconnect in the core top; the top ties off the AW/W/B channels.
- One transaction outstanding at a time.

Parameters:
ADDR_WIDTH, 32, physical address width (PROC_PALEN)
DATA_WIDTH, 32, AXI data width; only 32 is supported
LINE_WORDS, 4, words per cache line; power of 2, 2..16
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant value driven on ar_id

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  refill request valid
req_ready  out  1  request accepted when high with req_valid
req_paddr  in  ADDR_WIDTH  fetch physical address
req_uncached  in  1  1 = single-word uncached fetch
cancel  in  1  pipeline flush; discard the current transaction
rsp_valid  out  1  line ready
rsp_ready  in  1  ICache consumes the line
rsp_line  out  LINE_WORDS*DATA_WIDTH  line data; word i at bits [i*32 +: 32]
rsp_err  out  1  bus error during the transaction
ar_id/ar_addr/ar_len/ar_size/ar_burst/ar_lock/ar_cache/ar_prot/ar_qos/ar_user  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/1  AXI4 AR payload
ar_valid  out  1  AR valid
ar_ready  in  1  AR ready
r_id  in  ID_WIDTH  ignored
r_data  in  DATA_WIDTH  read data
r_resp  in  2  read response
r_last  in  1  last beat
r_valid  in  1  R valid
r_ready  out  1  R ready

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Reset values: state IDLE; req_ready=1; ar_valid=0; r_ready=0; rsp_valid=0; rsp_err=0; rsp_line=0; beat counter=0; drop flag=0.
- Constant AR fields: ar_id=AXI_ID, ar_size=3'b010, ar_burst=2'b01 (INCR), ar_lock=0, ar_prot=3'b100, ar_qos=0, ar_user=0.
- ar_cache: 4'b0011 for a cached request, 4'b0000 for an uncached one.
- States: IDLE, AR, RDATA, RESP, DRAIN.
- IDLE:
  - req_ready=1 only in this state.
  - On req_valid, register the request:
    - Cached: ar_addr = req_paddr with its low log2(LINE_WORDS*4) bits cleared; ar_len = LINE_WORDS-1.
    - Uncached: ar_addr = req_paddr with bits [1:0] cleared; ar_len = 0.
  - Clear rsp_err, the beat counter and the drop flag; go to AR. ar_valid rises the cycle after acceptance.
- AR:
  - ar_valid=1; all AR fields held stable until ar_ready.
  - On handshake: go to RDATA, or to DRAIN if the drop flag is set.
  - cancel never retracts ar_valid; it only sets the drop flag.
- RDATA:
  - r_ready=1.
  - On each beat, write r_data into word[beat counter], then increment the counter. The counter wraps at LINE_WORDS.
  - rsp_err |= r_resp[1].
  - Premature r_last (counter != ar_len) sets rsp_err.
  - On the r_last beat: go to RESP, or to IDLE if the drop flag is set.
  - cancel in RDATA (same cycle as a beat included) sets the drop flag; remaining beats are accepted and discarded.
- DRAIN: r_ready=1; beats discarded; go to IDLE on the r_last beat.
- RESP:
  - rsp_valid=1; rsp_line and rsp_err stable.
  - On rsp_ready: go to IDLE (req_ready=1 next cycle).
  - cancel in RESP: go to IDLE next cycle without a response. If cancel and rsp_ready are high together, cancel wins and rsp_ready is ignored.
- Uncached: the single word lands in word 0; the other words hold the previous buffer contents.
- Latency (ar_ready and r_valid tied high): request at cycle 0; AR handshake at cycle 1; beats at cycles 2..LINE_WORDS+1; rsp_valid at cycle LINE_WORDS+2.
- Reset asserted mid-burst returns to IDLE immediately. The interconnect is reset by the same rst, so no stale beats remain.

Optional Feature:
- Macro: ICACHE_REFILL_CRIT_WORD_FIRST_EN.
- Defined, cached requests only:
  - ar_burst=2'b10 (WRAP); ar_addr = req_paddr word-aligned, not line-aligned.
  - The beat counter starts at req_paddr word index and wraps modulo LINE_WORDS. Premature r_last (fewer than LINE_WORDS beats) sets rsp_err.
  - Extra ports: early_valid (out, 1) and early_word (out, DATA_WIDTH) pulse for one cycle with the first beat (the critical word), unless the drop flag is set or being set that cycle.
- Undefined: INCR from the line base as above; the early_* ports do not exist.
- Uncached requests behave identically in both builds.

Test Plan:
- Cached refill, paddr 0x1C00_0014, LINE_WORDS=4, ready tied high, beats 0xA0,0xA1,0xA2,0xA3 -> ar_addr=0x1C00_0010, ar_len=3, ar_burst=01; rsp_line[127:0]=0x000000A3_000000A2_000000A1_000000A0 at cycle 6; rsp_err=0.
- Uncached fetch, paddr 0xBFC0_0006 -> ar_addr=0xBFC0_0004, ar_len=0, ar_cache=0; word0 = r_data; rsp_valid one cycle after the beat.
- ar_ready held low 5 cycles, cancel pulsed on cycle 2 -> ar_addr/ar_len stable throughout; 4 beats drained with r_ready=1; no rsp_valid; req_ready returns after r_last.
- r_resp=2'b10 on beat 2 of 4 -> rsp_err=1 with rsp_valid; r_last on beat 2 with ar_len=3 -> rsp_err=1.
- rsp_ready held low 3 cycles in RESP -> rsp_valid/rsp_line stable; req_ready=0 until handshake; cancel plus rsp_ready in the same cycle -> IDLE, no consumption.
- With ICACHE_REFILL_CRIT_WORD_FIRST_EN: paddr 0x1C00_0018, beats B2,B3,B0,B1 -> ar_burst=10, ar_addr=0x1C00_0018; early_word=B2 on the first beat; rsp_line word order B0,B1,B2,B3.

Source files
------------

// File: rtl/icache_refill_axi_rd.sv
// AXI4 read master for ICache line refills and uncached fetches; one burst in flight.
// Optional ICACHE_REFILL_CRIT_WORD_FIRST_EN: WRAP bursts starting at the critical word, plus early_* ports.
module icache_refill_axi_rd #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_paddr,
    input  logic                             req_uncached,
    input  logic                             cancel,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_line,
    output logic                             rsp_err,
    output logic [ID_WIDTH-1:0]              ar_id,
    output logic [ADDR_WIDTH-1:0]            ar_addr,
    output logic [7:0]                       ar_len,
    output logic [2:0]                       ar_size,
    output logic [1:0]                       ar_burst,
    output logic                             ar_lock,
    output logic [3:0]                       ar_cache,
    output logic [2:0]                       ar_prot,
    output logic [3:0]                       ar_qos,
    output logic                             ar_user,
    output logic                             ar_valid,
    input  logic                             ar_ready,
    input  logic [ID_WIDTH-1:0]              r_id,
    input  logic [DATA_WIDTH-1:0]            r_data,
    input  logic [1:0]                       r_resp,
    input  logic                             r_last,
    input  logic                             r_valid,
    output logic                             r_ready
`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
    ,
    output logic                             early_valid,
    output logic [DATA_WIDTH-1:0]            early_word
`endif
);
    localparam int OFF = $clog2(LINE_WORDS * 4);
    localparam int CW  = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {IDLE, AR, RDATA, RESP, DRAIN} state_e;

    state_e                                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic [7:0]                             len_q, len_d;
    logic                                   cached_q, cached_d;
    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [CW-1:0]                          start_q, start_d;
    logic                                   drop_q, drop_d;
    logic                                   err_q, err_d;
    logic [LINE_WORDS-1:0][DATA_WIDTH-1:0]  line_q, line_d;
    logic [CW-1:0]                          beat_num;
    logic                                   drop_now;
    logic                                   unused_bits;

    assign unused_bits = ^{r_id, r_resp[0], req_paddr[1:0]};
    assign drop_now    = drop_q | cancel;
    // Beat ordinal within the burst; differs from the write index only for wrapped bursts.
    assign beat_num    = cnt_q - start_q;

    assign ar_id    = ID_WIDTH'(AXI_ID);
    assign ar_addr  = addr_q;
    assign ar_len   = len_q;
    assign ar_size  = 3'b010;
    assign ar_lock  = 1'b0;
    assign ar_cache = cached_q ? 4'b0011 : 4'b0000;
    assign ar_prot  = 3'b100;
    assign ar_qos   = 4'b0000;
    assign ar_user  = 1'b0;
    assign rsp_line = line_q;
    assign rsp_err  = err_q;

`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
    assign ar_burst    = cached_q ? 2'b10 : 2'b01;
    assign early_valid = (state_q == RDATA) && r_valid && cached_q && (cnt_q == start_q) && !drop_now;
    assign early_word  = r_data;
`else
    assign ar_burst = 2'b01;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cached_d  = cached_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        drop_d    = drop_q;
        err_d     = err_q;
        line_d    = line_q;
        req_ready = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cached_d = ~req_uncached;
                    start_d  = '0;
                    if (req_uncached) begin
                        addr_d = {req_paddr[ADDR_WIDTH-1:2], 2'b00};
                        len_d  = 8'd0;
                    end else begin
`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
                        addr_d  = {req_paddr[ADDR_WIDTH-1:2], 2'b00};
                        start_d = req_paddr[OFF-1:2];
`else
                        addr_d  = {req_paddr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
`endif
                        len_d  = 8'(LINE_WORDS - 1);
                    end
                    cnt_d   = start_d;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = AR;
                end
            end
            AR: begin
                ar_valid = 1'b1;
                if (cancel) drop_d = 1'b1;
                if (ar_ready) state_d = drop_now ? DRAIN : RDATA;
            end
            RDATA: begin
                r_ready = 1'b1;
                if (cancel) drop_d = 1'b1;
                if (r_valid) begin
                    if (!drop_now) line_d[cnt_q] = r_data;
                    cnt_d = cnt_q + 1'b1;
                    // A last beat arriving before the programmed burst length is a bus error.
                    err_d = err_q | r_resp[1] | (r_last && (8'(beat_num) != len_q));
                    if (r_last) state_d = drop_now ? IDLE : RESP;
                end
            end
            DRAIN: begin
                r_ready = 1'b1;
                if (r_valid && r_last) state_d = IDLE;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (cancel || rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            cached_q <= 1'b0;
            cnt_q    <= '0;
            start_q  <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cached_q <= cached_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            line_q   <= line_d;
        end
    end
endmodule

// File: tb/tb_icache_refill_axi_rd.sv
// Directed bench for icache_refill_axi_rd: a vector table of single transactions plus hand sequences.
module tb_icache_refill_axi_rd;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_uncached, cancel;
    logic [31:0]  req_paddr;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [127:0] rsp_line;
    logic [3:0]   ar_id;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic [2:0]   ar_size, ar_prot;
    logic [1:0]   ar_burst;
    logic         ar_lock, ar_user, ar_valid, ar_ready;
    logic [3:0]   ar_cache, ar_qos;
    logic [3:0]   r_id;
    logic [31:0]  r_data;
    logic [1:0]   r_resp;
    logic         r_last, r_valid, r_ready;
`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
    logic         early_valid;
    logic [31:0]  early_word;
`endif

    int total = 0;
    int bad   = 0;

    icache_refill_axi_rd dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr),
        .req_uncached(req_uncached), .cancel(cancel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_line(rsp_line), .rsp_err(rsp_err),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_lock(ar_lock), .ar_cache(ar_cache), .ar_prot(ar_prot),
        .ar_qos(ar_qos), .ar_user(ar_user), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
        , .early_valid(early_valid), .early_word(early_word)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       paddr;
        logic              unc;
        int                nb;
        logic [3:0][31:0]  beat;
        int                err_beat;
        logic [31:0]       exp_addr;
        logic [7:0]        exp_len;
        logic [3:0]        exp_cache;
        logic [127:0]      exp_line;
        logic              exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] pa, input logic unc);
        req_valid    = 1'b1;
        req_paddr    = pa;
        req_uncached = unc;
        chk("req_ready_idle", 128'(req_ready), 128'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Feeds n beats (data base+k), optionally asserting cancel alongside beat cxl_at.
    task automatic send_beats(input logic [31:0] base, input int n, input int cxl_at);
        for (int k = 0; k < n; k++) begin
            r_valid = 1'b1;
            r_data  = base + 32'(k);
            r_resp  = 2'b00;
            r_last  = (k == n - 1);
            cancel  = (k == cxl_at);
            chk("r_ready_beat", 128'(r_ready), 128'd1);
            step();
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        cancel  = 1'b0;
    endtask

    task automatic run_row(input int i, input vec_t v);
        ar_ready = 1'b1;
        start_req(v.paddr, v.unc);
        chk($sformatf("ar_valid[%0d]", i), 128'(ar_valid), 128'd1);
        chk($sformatf("ar_addr[%0d]", i), 128'(ar_addr), 128'(v.exp_addr));
        chk($sformatf("ar_len[%0d]", i), 128'(ar_len), 128'(v.exp_len));
        chk($sformatf("ar_cache[%0d]", i), 128'(ar_cache), 128'(v.exp_cache));
        chk($sformatf("ar_fixed[%0d]", i), 128'({ar_id, ar_size, ar_burst, ar_lock, ar_prot, ar_qos, ar_user}),
            128'({4'd0, 3'b010, 2'b01, 1'b0, 3'b100, 4'd0, 1'b0}));
        step();
        for (int k = 0; k < v.nb; k++) begin
            r_valid = 1'b1;
            r_data  = v.beat[k];
            r_resp  = (k == v.err_beat) ? 2'b10 : 2'b00;
            r_last  = (k == v.nb - 1);
            chk($sformatf("r_ready[%0d.%0d]", i, k), 128'(r_ready), 128'd1);
            step();
        end
        r_valid = 1'b0;
        r_last  = 1'b0;
        r_resp  = 2'b00;
        chk($sformatf("rsp_valid[%0d]", i), 128'(rsp_valid), 128'd1);
        chk($sformatf("rsp_line[%0d]", i), rsp_line, v.exp_line);
        chk($sformatf("rsp_err[%0d]", i), 128'(rsp_err), 128'(v.exp_err));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk($sformatf("req_ready_after[%0d]", i), 128'(req_ready), 128'd1);
        chk($sformatf("rsp_valid_after[%0d]", i), 128'(rsp_valid), 128'd0);
    endtask

    initial begin
        tbl[0] = '{32'h1C00_0014, 1'b0, 4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 99,
                   32'h1C00_0010, 8'd3, 4'h3, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0};
        tbl[1] = '{32'hBFC0_0006, 1'b1, 1, {32'h0, 32'h0, 32'h0, 32'h1234_5678}, 99,
                   32'hBFC0_0004, 8'd0, 4'h0, 128'h000000A3_000000A2_000000A1_12345678, 1'b0};
        tbl[2] = '{32'h0000_0100, 1'b0, 4, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 1,
                   32'h0000_0100, 8'd3, 4'h3, 128'h000000D3_000000D2_000000D1_000000D0, 1'b1};
        tbl[3] = '{32'h0000_0204, 1'b0, 2, {32'h0, 32'h0, 32'hE1, 32'hE0}, 99,
                   32'h0000_0200, 8'd3, 4'h3, 128'h000000D3_000000D2_000000E1_000000E0, 1'b1};
        tbl[4] = '{32'h3FFF_FFFC, 1'b0, 4, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 99,
                   32'h3FFF_FFF0, 8'd3, 4'h3, 128'h000000F3_000000F2_000000F1_000000F0, 1'b0};
        tbl[5] = '{32'h0000_0003, 1'b1, 1, {32'h0, 32'h0, 32'h0, 32'hCAFE_0000}, 99,
                   32'h0000_0000, 8'd0, 4'h0, 128'h000000F3_000000F2_000000F1_CAFE0000, 1'b0};

        rst = 1'b1; req_valid = 0; req_paddr = 0; req_uncached = 0; cancel = 0; rsp_ready = 0;
        ar_ready = 0; r_id = 4'h5; r_data = 0; r_resp = 0; r_last = 0; r_valid = 0;
        step(); step();
        chk("rst_req_ready", 128'(req_ready), 128'd1);
        chk("rst_ar_valid", 128'(ar_valid), 128'd0);
        chk("rst_r_ready", 128'(r_ready), 128'd0);
        chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("rst_rsp_err", 128'(rsp_err), 128'd0);
        chk("rst_rsp_line", rsp_line, 128'd0);
        rst = 1'b0;
        step();

`ifndef ICACHE_REFILL_CRIT_WORD_FIRST_EN
        for (int i = 0; i < 6; i++) run_row(i, tbl[i]);

        // AR stalled 5 cycles with cancel: burst drained, line untouched, no response.
        ar_ready = 1'b0;
        start_req(32'h1C00_0020, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            cancel = (c == 2);
            chk("stall_ar_valid", 128'(ar_valid), 128'd1);
            chk("stall_ar_addr", 128'(ar_addr), 128'h1C00_0020);
            chk("stall_ar_len", 128'(ar_len), 128'd3);
            step();
        end
        cancel = 1'b0;
        ar_ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            r_valid = 1'b1; r_data = 32'hDEAD_0000 + 32'(k); r_last = (k == 3);
            chk("drain_r_ready", 128'(r_ready), 128'd1);
            chk("drain_no_rsp", 128'(rsp_valid), 128'd0);
            chk("drain_no_req", 128'(req_ready), 128'd0);
            step();
        end
        r_valid = 1'b0; r_last = 1'b0;
        chk("drain_req_ready", 128'(req_ready), 128'd1);
        chk("drain_rsp_valid", 128'(rsp_valid), 128'd0);
        chk("drain_line_kept", rsp_line, 128'h000000F3_000000F2_000000F1_CAFE0000);
`endif

        // Response back-pressure: everything holds until rsp_ready.
        ar_ready = 1'b1;
        start_req(32'h0000_0040, 1'b0);
        step();
        send_beats(32'h11, 4, -1);
        for (int c = 0; c < 3; c++) begin
            chk("hold_rsp_valid", 128'(rsp_valid), 128'd1);
            chk("hold_rsp_line", rsp_line, 128'h00000014_00000013_00000012_00000011);
            chk("hold_req_ready", 128'(req_ready), 128'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hold_release", 128'(req_ready), 128'd1);

        // Cancel together with rsp_ready in RESP.
        start_req(32'h0000_0080, 1'b0);
        step();
        send_beats(32'h21, 4, -1);
        chk("cxl_resp_valid", 128'(rsp_valid), 128'd1);
        cancel = 1'b1; rsp_ready = 1'b1;
        step();
        cancel = 1'b0; rsp_ready = 1'b0;
        chk("cxl_resp_idle", 128'(req_ready), 128'd1);
        chk("cxl_resp_gone", 128'(rsp_valid), 128'd0);

        // Cancel on the last beat itself: straight back to IDLE.
        start_req(32'h0000_00C0, 1'b0);
        step();
        send_beats(32'h31, 4, 3);
        chk("cxl_last_idle", 128'(req_ready), 128'd1);
        chk("cxl_last_no_rsp", 128'(rsp_valid), 128'd0);

        // Synchronous reset in the middle of a burst.
        start_req(32'h0000_0100, 1'b0);
        step();
        send_beats(32'h41, 1, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_req_ready", 128'(req_ready), 128'd1);
        chk("midrst_r_ready", 128'(r_ready), 128'd0);
        chk("midrst_ar_valid", 128'(ar_valid), 128'd0);
        chk("midrst_line", rsp_line, 128'd0);

`ifdef ICACHE_REFILL_CRIT_WORD_FIRST_EN
        // Critical word first: WRAP burst from word 2, early pulse on first beat.
        start_req(32'h1C00_0018, 1'b0);
        chk("cwf_ar_addr", 128'(ar_addr), 128'h1C00_0018);
        chk("cwf_ar_burst", 128'(ar_burst), 128'd2);
        step();
        for (int k = 0; k < 4; k++) begin
            r_valid = 1'b1;
            r_data  = 32'hB0 + 32'((k + 2) % 4);
            r_last  = (k == 3);
            #1;
            chk("cwf_early_valid", 128'(early_valid), (k == 0) ? 128'd1 : 128'd0);
            if (k == 0) chk("cwf_early_word", 128'(early_word), 128'hB2);
            step();
        end
        r_valid = 1'b0; r_last = 1'b0;
        chk("cwf_rsp_valid", 128'(rsp_valid), 128'd1);
        chk("cwf_rsp_line", rsp_line, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("cwf_rsp_err", 128'(rsp_err), 128'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
